gray_input_sampler: RTL
=======================

Name: gray_input_sampler

Overview:
- Upstream stage of the 4-bit Gray-to-binary converter.
- Takes the raw Gray word from board switches, which is asynchronous and bouncy.
- Synchronizes it, debounces it, and presents one stable registered Gray word to the converter.
- Flags each accepted update with a one-cycle valid pulse and a step-error pulse when the accepted change is not a legal single-bit Gray step.

Parameters:
- WIDTH, 4: Gray word width. Fixed at 4 for the converter; the RTL stays generic.
- STABLE_CYCLES, 500000: consecutive cycles a new value must hold before acceptance (10 ms at 50 MHz). Must be ≥2.
- CNT_W, $clog2(STABLE_CYCLES): debounce counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- gray_raw  input  WIDTH  raw switch Gray word; asynchronous to clk.
- gray_out  output  WIDTH  debounced, registered Gray word; drives the converter's gray_in.
- gray_valid  output  1  one-cycle pulse in the cycle gray_out takes a new value.
- step_err  output  1  one-cycle pulse, coincident with gray_valid, when old and new gray_out differ in ≠1 bit.
- settling  output  1  high while a candidate value is being timed (state SETTLE).

Behaviour:
- Reset (rst_n=0, asynchronous): sync stages, candidate, gray_out, and cnt are all 0; state is STABLE; gray_valid, step_err, and settling are all 0.
- Synchronizer: 2 flip-flops per bit. Only the second stage (sync_q) feeds the logic.
- FSM states: STABLE, SETTLE.
- STABLE:
  - If sync_q ≠ gray_out: candidate ← sync_q, cnt ← 0, go to SETTLE.
  - Otherwise hold.
- SETTLE, evaluated in this priority order:
  1. sync_q == gray_out (bounced back): go to STABLE, cnt ← 0, no pulse.
  2. sync_q ≠ candidate (new bounce value): candidate ← sync_q, cnt ← 0, stay in SETTLE.
  3. cnt == STABLE_CYCLES−1: gray_out ← candidate, gray_valid ← 1, step_err ← (popcount(candidate ^ gray_out) ≠ 1), go to STABLE.
  4. Otherwise cnt ← cnt+1.
- Latency: gray_out updates on the (STABLE_CYCLES+2)th rising edge after the edge that first captures the new value into sync stage 1. This assumes the input is held stable throughout.
- gray_valid and step_err are registered and high for exactly one cycle. They are never asserted without a gray_out change.
- settling is a registered decode of state == SETTLE.
- cnt never exceeds STABLE_CYCLES−1; no wrap-around.
- Multi-bit jumps are still accepted (gray_out updates) but flagged by step_err. The block never rejects data.
- Reset asserted mid-SETTLE: immediate return to reset values; the pending candidate is discarded.
- After reset deassertion with nonzero switches, a normal debounce accepts the value. That first acceptance may flag step_err if more than 1 bit differs from 0.

Decomposition:
- Package gray_sampler_pkg:
  - typedef enum logic {STABLE, SETTLE} sampler_state_t
  - localparam GRAY_W = 4
- Sub-module sync_2ff (params WIDTH; ports clk, rst_n, d, q): a two-stage synchronizer, reusable for other switch inputs.
- Popcount check is local combinational logic in gray_input_sampler.

Test Plan (STABLE_CYCLES=4 in sim):
- Reset check: rst_n=0 with gray_raw=4'b1010 → gray_out=0, gray_valid=0, step_err=0, settling=0 throughout reset.
- Clean legal step: from gray_out=0000, apply gray_raw=0001 and hold → gray_out=0001 exactly 6 edges after first capture. gray_valid pulses 1 cycle, step_err=0, settling high for 4 cycles.
- Bounce rejection: from 0001, toggle gray_raw 0011/0001 every 2 cycles for 20 cycles, then hold 0001 → gray_out stays 0001, gray_valid never asserts.
- Bounce then settle: from 0001, toggle 0011/0111 every 2 cycles, then hold 0011 → exactly one gray_valid, gray_out=0011, step_err=0; the intermediate 0111 is never output.
- Illegal jump: from 0011, hold gray_raw=1100 → gray_out=1100, gray_valid=1 and step_err=1 in the same single cycle.
- Reset mid-settle: from 0000, drive 0001, assert rst_n=0 two cycles into SETTLE while keeping gray_raw=0001 → outputs immediately 0. After release, 0001 is re-accepted after the full latency with one gray_valid.

Source files
------------

// File: rtl/gray_sampler_pkg.sv
// Shared types and constants for the Gray switch sampler.
package gray_sampler_pkg;

    localparam int GRAY_W = 4;

    typedef enum logic {
        STABLE,
        SETTLE
    } sampler_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for asynchronous level inputs such as board switches.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gray_input_sampler.sv
// Synchronizes and debounces a raw switch Gray word, presenting one stable
// registered word with an update pulse and an illegal-step flag.
module gray_input_sampler
    import gray_sampler_pkg::*;
#(
    parameter int WIDTH         = GRAY_W,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_raw,
    output logic [WIDTH-1:0] gray_out,
    output logic             gray_valid,
    output logic             step_err,
    output logic             settling
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] W_ONE   = WIDTH'(1);

    sampler_state_t   state_q, state_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             settling_q;
    logic [WIDTH-1:0] diff;
    logic             one_bit_step;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gray_raw),
        .q     (sync_q)
    );

    // popcount == 1 is equivalent to: nonzero and a power of two
    assign diff         = cand_q ^ gray_q;
    assign one_bit_step = (diff != '0) && ((diff & (diff - W_ONE)) == '0);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        gray_d  = gray_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            STABLE: begin
                if (sync_q != gray_q) begin
                    cand_d  = sync_q;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sync_q == gray_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (sync_q != cand_q) begin
                    cand_d = sync_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    gray_d  = cand_q;
                    valid_d = 1'b1;
                    err_d   = !one_bit_step;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = STABLE;
        endcase
    end

    // settling follows the next state so it lines up with state_q itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STABLE;
            cand_q     <= '0;
            gray_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            settling_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            gray_q     <= gray_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            settling_q <= (state_d == SETTLE);
        end
    end

    assign gray_out   = gray_q;
    assign gray_valid = valid_q;
    assign step_err   = err_q;
    assign settling   = settling_q;

endmodule
